tpram_fwd_syn: RTL and testbench
================================

// Module: tpram_fwd_syn
// PURPOSE
//  Single-clock two-port RAM (one write port, one read port) with per-bit write enable.
//  Read latency is parametrised; the read pipeline carries a valid flag and can be stalled.
//  Optional write-to-read forwarding on same-address collisions; saturating collision counter.
//  Drop-in successor for buffer/line-store RAMs in single-clock datapaths that need latency tracking and stalls.
// PARAMETERS
//  DATA_DEPTH  16   number of words; need not be a power of 2
//  DATA_WIDTH  64   bits per word
//  RD_DELAY    1    read latency in cycles (>=1; 0 is an elaboration error)
//  FWD_EN      1    1: a same-cycle same-address read returns the new data for written bits; 0: read-first (old data)
//  CNT_WIDTH   8    width of coll_cnt
//  ADDR_WIDTH  (DATA_DEPTH>1)?$clog2(DATA_DEPTH):1   derived, not overridden
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  wena       in   1           write enable
//  addra      in   ADDR_WIDTH  write address
//  dina       in   DATA_WIDTH  write data
//  bwea       in   DATA_WIDTH  per-bit write mask, 1 = write this bit
//  enb        in   1           read request
//  addrb      in   ADDR_WIDTH  read address
//  hold       in   1           stall: freezes the read pipeline
//  doutb      out  DATA_WIDTH  read data, last pipeline stage
//  doutb_vld  out  1           doutb holds the result of a read request
//  coll_cnt   out  CNT_WIDTH   saturating count of read/write address collisions
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - Clears all pipeline data and valid registers, so doutb=0, doutb_vld=0, coll_cnt=0.
//   - Memory array is not reset; its contents are undefined until written.
//   - Writes are ignored while rst=1. Reads in flight are dropped; doutb_vld=0 after the reset edge.
//  Write (rst=0):
//   - On posedge with wena=1: mem[addra][i] <= dina[i] for every bit i with bwea[i]=1. Other bits keep their value.
//   - hold has no effect on writes.
//   - addra >= DATA_DEPTH: the write is ignored.
//  Read stage 0 (rst=0, hold=0):
//   - vld[0] <= enb.
//   - If enb=1: d[0] <= rd_word; if enb=0, d[0] keeps its value.
//   - rd_word = mem[addrb] (pre-write contents of this cycle).
//   - If FWD_EN=1 and wena=1 and addra==addrb: rd_word = (dina & bwea) | (mem[addrb] & ~bwea).
//   - addrb >= DATA_DEPTH: rd_word = 0.
//  Stages k=1..RD_DELAY-1 (rst=0, hold=0): d[k] <= d[k-1] and vld[k] <= vld[k-1].
//  Latency: a read with enb=1 at edge N (no hold) gives doutb_vld=1 with the data after edge N+RD_DELAY-1,
//   i.e. RD_DELAY cycles after the request is presented.
//  hold=1: no stage advances and enb is ignored (the request is lost; the requester must hold it).
//   doutb and doutb_vld stay stable. Order is preserved and no accepted read is lost.
//  doutb = d[RD_DELAY-1]; doutb_vld = vld[RD_DELAY-1].
//  Collision = wena & enb & ~hold & (addra==addrb) & ~rst.
//   - Each collision adds 1 to coll_cnt; coll_cnt saturates at 2^CNT_WIDTH-1 and does not wrap.
//   - Only rst clears coll_cnt.
//   - Collisions are counted regardless of FWD_EN.
//  With FWD_EN=0, a collision returns the old data for every bit.
// TESTING
//  T1 rst for 2 cycles, then idle -> doutb=0, doutb_vld=0, coll_cnt=0.
//  T2 RD_DELAY=3; write addr 3 with 64'hA5A5_0000_FFFF_1234, bwea all 1s; next cycle enb addr 3
//     -> doutb_vld=1 exactly 3 cycles later with the written value, for one cycle only.
//  T3 Write addr 7 with all 1s; then dina=0, bwea=64'h00FF -> read addr 7 returns 64'hFFFF_FFFF_FFFF_FF00.
//  T4 mem[5]=64'h1111, then same cycle wena addr 5 dina=64'h2222 bwea=64'h00FF plus enb addr 5
//     -> FWD_EN=1 returns 64'h1122, FWD_EN=0 returns 64'h1111; coll_cnt=1 in both cases.
//  T5 RD_DELAY=2; reads of addr 0,1,2 on back-to-back cycles; hold=1 for 3 cycles after the second read
//     -> doutb/doutb_vld frozen during hold; then data 0,1,2 in order; a read issued during hold is not returned.
//  T6 CNT_WIDTH=2, 5 collisions -> coll_cnt=3. Then rst while a read is in flight
//     -> coll_cnt=0 and doutb_vld=0 after the reset edge; the in-flight read never appears.

Source files
------------

// File: rtl/tpram_fwd_syn.sv
// tpram_fwd_syn
//   Single-clock two-port RAM: one write port with a per-bit write mask and one
//   read port whose latency is set by a parameter. The read pipeline carries a
//   valid flag alongside the data, and the pipeline can be stalled. When FWD_EN
//   is set, a read and a write to the same address in the same cycle return the
//   newly written bits. Otherwise the read returns the old word. A saturating
//   counter records read/write address collisions.
//
// Ports
//   clk        in   clock; all logic is on the rising edge
//   rst        in   synchronous reset, active high
//   wena       in   write enable
//   addra      in   write address
//   dina       in   write data
//   bwea       in   per-bit write mask (1 = write this bit)
//   enb        in   read request
//   addrb      in   read address
//   hold       in   freezes the read pipeline; a request made while hold=1 is dropped
//   doutb      out  read data from the last pipeline stage
//   doutb_vld  out  doutb holds the result of a read request
//   coll_cnt   out  saturating count of same-address read/write collisions
module tpram_fwd_syn #(
  parameter  int DATA_DEPTH = 16,
  parameter  int DATA_WIDTH = 64,
  parameter  int RD_DELAY   = 1,
  parameter  int FWD_EN     = 1,
  parameter  int CNT_WIDTH  = 8,
  localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] bwea,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  doutb_vld,
  output logic [CNT_WIDTH-1:0]  coll_cnt
);

  if (RD_DELAY < 1) begin : g_bad_rd_delay
    $error("tpram_fwd_syn: RD_DELAY must be at least 1");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] d   [RD_DELAY];
  logic [RD_DELAY-1:0]   vld;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  same_addr;
  logic                  coll;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_in_range = 32'(addra) < DATA_DEPTH;
  assign rd_in_range = 32'(addrb) < DATA_DEPTH;
  assign same_addr   = (addra == addrb);
  assign coll        = wena & enb & ~hold & same_addr & ~rst;

  // An out-of-range read returns zero. This takes priority over forwarding,
  // so an out-of-range collision never returns write data.
  always_comb begin
    mem_word = '0;
    rd_word  = '0;
    if (rd_in_range) begin
      mem_word = mem[addrb];
      rd_word  = mem_word;
      if ((FWD_EN != 0) && wena && same_addr) begin
        rd_word = (dina & bwea) | (mem_word & ~bwea);
      end
    end
  end

  // The memory array is not reset. Its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (!rst && wena && wr_in_range) begin
      mem[addra] <= (mem[addra] & ~bwea) | (dina & bwea);
    end
  end

  // When enb=0, d[0] keeps its value. Only the valid flag marks the slot as empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_DELAY; k++) begin
        d[k]   <= '0;
        vld[k] <= 1'b0;
      end
    end else if (!hold) begin
      vld[0] <= enb;
      if (enb) begin
        d[0] <= rd_word;
      end
      for (int k = 1; k < RD_DELAY; k++) begin
        d[k]   <= d[k-1];
        vld[k] <= vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt <= '0;
    end else if (coll && (coll_cnt != CNT_MAX)) begin
      coll_cnt <= coll_cnt + 1'b1;
    end
  end

  assign doutb     = d[RD_DELAY-1];
  assign doutb_vld = vld[RD_DELAY-1];

endmodule

// File: tb/tb_tpram_fwd_syn.sv
module tb_tpram_fwd_syn;
  localparam int DW    = 64;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NI    = 3;
  localparam int RDD     [NI] = '{3, 2, 1};
  localparam int FWD     [NI] = '{1, 0, 1};
  localparam int CNT_MAX [NI] = '{255, 3, 3};

  logic          clk = 1'b0;
  logic          rst, wena, enb, hold;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, bwea;
  logic [DW-1:0] dout [NI];
  logic          vld  [NI];
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b, cnt_c;

  always #5 clk = ~clk;

  tpram_fwd_syn #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_DELAY(3), .FWD_EN(1), .CNT_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bwea(bwea),
    .enb(enb), .addrb(addrb), .hold(hold), .doutb(dout[0]), .doutb_vld(vld[0]), .coll_cnt(cnt_a));
  tpram_fwd_syn #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_DELAY(2), .FWD_EN(0), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bwea(bwea),
    .enb(enb), .addrb(addrb), .hold(hold), .doutb(dout[1]), .doutb_vld(vld[1]), .coll_cnt(cnt_b));
  tpram_fwd_syn #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_DELAY(1), .FWD_EN(1), .CNT_WIDTH(2)) u_c (
    .clk(clk), .rst(rst), .wena(wena), .addra(addra), .dina(dina), .bwea(bwea),
    .enb(enb), .addrb(addrb), .hold(hold), .doutb(dout[2]), .doutb_vld(vld[2]), .coll_cnt(cnt_c));

  // Reference model: a word array, plus one history queue per instance that
  // holds the last RDD accepted read slots. The front of a queue is what that
  // instance should present.
  typedef struct {
    bit            v;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          hist [NI][$];
  logic [DW-1:0] mem_m [DEPTH];
  int unsigned   cnt_m [NI];
  int            vectors = 0;
  int            errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int i);
    logic [DW-1:0] old;
    if (int'(addrb) >= DEPTH) return '0;
    old = mem_m[addrb];
    if (FWD[i] != 0 && wena && addra == addrb) return (dina & bwea) | (old & ~bwea);
    return old;
  endfunction

  task automatic model_edge();
    ent_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        hist[i].delete();
        for (int k = 0; k < RDD[i]; k++) begin
          e.v = 1'b0;
          e.d = '0;
          hist[i].push_back(e);
        end
        cnt_m[i] = 0;
      end else if (!hold) begin
        e.v = enb;
        e.d = enb ? ref_read(i) : hist[i][$].d;
        hist[i].push_back(e);
        void'(hist[i].pop_front());
        if (wena && enb && addra == addrb && cnt_m[i] < CNT_MAX[i]) cnt_m[i]++;
      end
    end
    if (!rst && wena && int'(addra) < DEPTH)
      mem_m[addra] = (mem_m[addra] & ~bwea) | (dina & bwea);
  endtask

  task automatic check_all();
    logic [63:0] c;
    for (int i = 0; i < NI; i++) begin
      c = (i == 0) ? 64'(cnt_a) : (i == 1) ? 64'(cnt_b) : 64'(cnt_c);
      chk($sformatf("doutb[%0d]", i), dout[i], hist[i][0].d);
      chk($sformatf("doutb_vld[%0d]", i), 64'(vld[i]), 64'(hist[i][0].v));
      chk($sformatf("coll_cnt[%0d]", i), c, 64'(cnt_m[i]));
    end
  endtask

  // Called at a negedge: apply the inputs, let one posedge pass, then compare at the next negedge.
  task automatic drive(input bit r, input bit we, input logic [AW-1:0] aa, input logic [DW-1:0] di,
                       input logic [DW-1:0] bw, input bit re, input logic [AW-1:0] ab, input bit h);
    rst = r; wena = we; addra = aa; dina = di; bwea = bw; enb = re; addrb = ab; hold = h;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; wena = 0; enb = 0; hold = 0; addra = 0; addrb = 0; dina = '0; bwea = '0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    @(negedge clk);

    // Reset for two cycles, then idle.
    drive(1, 0, 0, '0, '0, 0, 0, 0);
    drive(1, 0, 0, '0, '0, 0, 0, 0);
    idle(2);

    // Fill every word, including the out-of-range addresses (those writes must be ignored).
    for (int a = 0; a < 16; a++) drive(0, 1, AW'(a), {$urandom, $urandom}, '1, 0, 0, 0);

    // Full-word write, then a read on the next cycle; 3-cycle latency on u_a.
    drive(0, 1, 3, 64'hA5A5_0000_FFFF_1234, '1, 0, 0, 0);
    drive(0, 0, 0, '0, '0, 1, 3, 0);
    idle(2);
    chk("t2_data", dout[0], 64'hA5A5_0000_FFFF_1234);
    chk("t2_vld", 64'(vld[0]), 64'd1);
    idle(1);
    chk("t2_vld_drop", 64'(vld[0]), 64'd0);

    // Masked write.
    drive(0, 1, 7, '1, '1, 0, 0, 0);
    drive(0, 1, 7, '0, 64'h00FF, 0, 0, 0);
    drive(0, 0, 0, '0, '0, 1, 7, 0);
    chk("t3_mask", dout[2], 64'hFFFF_FFFF_FFFF_FF00);

    // Same-address collision: forwarding versus read-first.
    drive(0, 1, 5, 64'h1111, '1, 0, 0, 0);
    drive(0, 1, 5, 64'h2222, 64'h00FF, 1, 5, 0);
    chk("t4_fwd_c", dout[2], 64'h1122);
    chk("t4_cnt_a", 64'(cnt_a), 64'd1);
    chk("t4_cnt_b", 64'(cnt_b), 64'd1);
    idle(1);
    chk("t4_nofwd_b", dout[1], 64'h1111);
    idle(1);
    chk("t4_fwd_a", dout[0], 64'h1122);

    // Stall: reads 0 and 1, three hold cycles with a request that must be lost, then read 2.
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    drive(0, 0, 0, '0, '0, 1, 1, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, '0, '0, 1, 9, 1);
    drive(0, 0, 0, '0, '0, 1, 2, 0);
    idle(4);

    // Counter saturation, then a reset while a read is in flight.
    for (int k = 0; k < 5; k++) drive(0, 1, 1, {$urandom, $urandom}, '1, 1, 1, 0);
    chk("t6_sat_b", 64'(cnt_b), 64'd3);
    chk("t6_sat_c", 64'(cnt_c), 64'd3);
    drive(0, 0, 0, '0, '0, 1, 4, 0);
    drive(1, 0, 0, '0, '0, 0, 0, 0);
    chk("t6_rst_vld", 64'(vld[0]), 64'd0);
    chk("t6_rst_cnt", 64'(cnt_a), 64'd0);
    idle(4);

    // Random traffic with frequent collisions, holds and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] aa, ab;
      logic [DW-1:0] bw;
      aa = AW'($urandom_range(0, 15));
      ab = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, 15));
      bw = ($urandom_range(0, 1) == 0) ? '1 : {$urandom, $urandom};
      drive($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), aa, {$urandom, $urandom}, bw,
            1'($urandom_range(0, 1)), ab, $urandom_range(0, 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
